// File: rtl/pd_math_pkg.sv
// pd_math_pkg: shared widths, error type and signed saturation for the PD datapath
package pd_math_pkg;
  localparam int ERR_W = 10;
  localparam int DDIFF_W = 7;
  localparam int PTERM_W = 10;
  localparam int DTERM_W = 12;
  typedef logic signed [ERR_W-1:0] err_t;
  function automatic logic signed [16:0] sat_signed(input logic signed [16:0] v, input int w);
    logic signed [16:0] hi, lo;
    hi = (17'sd1 <<< (w - 1)) - 17'sd1;
    lo = -(17'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/pd_hist_queue.sv
// pd_hist_queue: per-channel circular error history; PD_MATH_MC_HIST_CLR_EN adds fill counters and hist_clr
module pd_hist_queue
  import pd_math_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int D_QUEUE_DEPTH = 12,
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int PW = D_QUEUE_DEPTH > 1 ? $clog2(D_QUEUE_DEPTH) : 1,
  localparam int CW = $clog2(D_QUEUE_DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [CHW-1:0] ch,
  input  err_t wdata,
`ifdef PD_MATH_MC_HIST_CLR_EN
  input  logic [NUM_CH-1:0] hist_clr,
`endif
  output err_t rdata
);
  err_t mem_q [NUM_CH][D_QUEUE_DEPTH];
  err_t mem_d [NUM_CH][D_QUEUE_DEPTH];
  logic [PW-1:0] ptr_q [NUM_CH];
  logic [PW-1:0] ptr_d [NUM_CH];
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (wr_en) begin
      mem_d[ch][ptr_q[ch]] = wdata;
      ptr_d[ch] = ptr_q[ch] == PW'(D_QUEUE_DEPTH - 1) ? '0 : ptr_q[ch] + PW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      ptr_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
    end
  end
`ifdef PD_MATH_MC_HIST_CLR_EN
  logic [CW-1:0] cnt_q [NUM_CH];
  logic [CW-1:0] cnt_d [NUM_CH];
  // a clear beats a same-cycle write; the entry itself is still written above
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      cnt_d[i] = hist_clr[i] ? '0 :
                 (wr_en && ch == CHW'(i) && cnt_q[i] != CW'(D_QUEUE_DEPTH)) ? cnt_q[i] + CW'(1) : cnt_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
  end
  assign rdata = cnt_q[ch] < CW'(D_QUEUE_DEPTH) ? '0 : mem_q[ch][ptr_q[ch]];
`else
  assign rdata = mem_q[ch][ptr_q[ch]];
`endif
endmodule

// File: rtl/pd_math_mc.sv
// pd_math_mc: time-multiplexed 3-stage PD datapath over NUM_CH channels; PD_MATH_MC_HIST_CLR_EN adds hist_clr
module pd_math_mc
  import pd_math_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int D_QUEUE_DEPTH = 12,
  parameter logic signed [4:0] DTERM_GAIN = 5'sd7,
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  output logic in_rdy,
  input  logic [CHW-1:0] in_ch,
  input  logic [15:0] desired,
  input  logic [15:0] actual,
`ifdef PD_MATH_MC_HIST_CLR_EN
  input  logic [NUM_CH-1:0] hist_clr,
`endif
  output logic out_vld,
  input  logic out_rdy,
  output logic [CHW-1:0] out_ch,
  output logic [PTERM_W-1:0] pterm,
  output logic [DTERM_W-1:0] dterm
);
  logic en, s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, out_vld_q, out_vld_d;
  logic [CHW-1:0] s1_ch_q, s1_ch_d, s2_ch_q, s2_ch_d, out_ch_q, out_ch_d;
  err_t s1_err_q, s1_err_d, prev;
  logic signed [PTERM_W-1:0] s2_p_q, s2_p_d, pterm_q, pterm_d;
  logic signed [DDIFF_W-1:0] s2_dd_q, s2_dd_d;
  logic signed [DTERM_W-1:0] dterm_q, dterm_d;
  logic signed [10:0] diff;
  // one enable freezes every stage together while the output is held
  always_comb begin
    en = !(out_vld_q && !out_rdy);
    diff = 11'(s1_err_q) - 11'(prev);
    s1_vld_d = en ? in_vld : s1_vld_q;
    s1_ch_d = en ? in_ch : s1_ch_q;
    s1_err_d = en ? err_t'(sat_signed(17'($signed(actual)) - 17'($signed(desired)), ERR_W)) : s1_err_q;
    s2_vld_d = en ? s1_vld_q : s2_vld_q;
    s2_ch_d = en ? s1_ch_q : s2_ch_q;
    s2_p_d = en ? (s1_err_q >>> 1) + (s1_err_q >>> 3) : s2_p_q;
    s2_dd_d = en ? DDIFF_W'(sat_signed(17'(diff), DDIFF_W)) : s2_dd_q;
    out_vld_d = en ? s2_vld_q : out_vld_q;
    out_ch_d = en ? s2_ch_q : out_ch_q;
    pterm_d = en ? s2_p_q : pterm_q;
    dterm_d = en ? DTERM_W'(s2_dd_q) * DTERM_W'(DTERM_GAIN) : dterm_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      s1_ch_q <= '0;
      s2_ch_q <= '0;
      out_ch_q <= '0;
      s1_err_q <= '0;
      s2_p_q <= '0;
      s2_dd_q <= '0;
      pterm_q <= '0;
      dterm_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      out_vld_q <= out_vld_d;
      s1_ch_q <= s1_ch_d;
      s2_ch_q <= s2_ch_d;
      out_ch_q <= out_ch_d;
      s1_err_q <= s1_err_d;
      s2_p_q <= s2_p_d;
      s2_dd_q <= s2_dd_d;
      pterm_q <= pterm_d;
      dterm_q <= dterm_d;
    end
  end
  pd_hist_queue #(.NUM_CH(NUM_CH), .D_QUEUE_DEPTH(D_QUEUE_DEPTH)) u_hist (
    .clk(clk),
    .rst(rst),
    .wr_en(en && s1_vld_q),
    .ch(s1_ch_q),
    .wdata(s1_err_q),
`ifdef PD_MATH_MC_HIST_CLR_EN
    .hist_clr(hist_clr),
`endif
    .rdata(prev)
  );
  assign in_rdy = en;
  assign out_vld = out_vld_q;
  assign out_ch = out_ch_q;
  assign pterm = pterm_q;
  assign dterm = dterm_q;
endmodule

// File: tb/tb_pd_math_mc.sv
// tb_pd_math_mc: randomized and directed checks of pd_math_mc against a queue-based reference model
module tb_pd_math_mc;
  localparam int D = 12;
  logic clk = 1'b0;
  logic rst, in_vld, in_rdy, out_vld, out_rdy;
  logic [1:0] in_ch, out_ch;
  logic [15:0] desired, actual;
  logic [9:0] pterm;
  logic [11:0] dterm;
`ifdef PD_MATH_MC_HIST_CLR_EN
  logic [2:0] hist_clr = '0;
`endif
  pd_math_mc dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_ch(in_ch),
    .desired(desired), .actual(actual),
`ifdef PD_MATH_MC_HIST_CLR_EN
    .hist_clr(hist_clr),
`endif
    .out_vld(out_vld), .out_rdy(out_rdy), .out_ch(out_ch), .pterm(pterm), .dterm(dterm)
  );
  always #5 clk = ~clk;
  typedef struct {int ch; int p; int d;} res_t;
  res_t exp_q[$];
  int hist[3][$];
  int n_vec = 0, n_err = 0;
  int last_p[3], last_d[3], last_ch, ch2_441 = 0;
  int e, pv;
  task automatic check(string tag, int got, int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask
  function automatic int sat(int v, int w);
    int hi = (1 << (w - 1)) - 1;
    return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
  endfunction
  task automatic model_reset();
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      hist[c].delete();
      repeat (D) hist[c].push_back(0);
    end
  endtask
  // reference model: history is a FIFO of the last D errors per channel
  always @(negedge clk) begin
    if (rst) model_reset();
    else begin
      if (out_vld) begin
        if (exp_q.size() == 0) check("spurious_out", int'(out_vld), 0);
        else begin
          check("out_ch", int'(out_ch), exp_q[0].ch);
          check("pterm", int'($signed(pterm)), exp_q[0].p);
          check("dterm", int'($signed(dterm)), exp_q[0].d);
          if (out_rdy) begin
            void'(exp_q.pop_front());
            last_ch = int'(out_ch);
            last_p[out_ch] = int'($signed(pterm));
            last_d[out_ch] = int'($signed(dterm));
            if (out_ch == 2'd2 && $signed(dterm) == 12'sd441) ch2_441++;
          end
        end
      end
      if (in_vld && in_rdy) begin
        e = sat(int'($signed(actual)) - int'($signed(desired)), 10);
        pv = hist[in_ch].pop_front();
        hist[in_ch].push_back(e);
        exp_q.push_back(res_t'{int'(in_ch), (e >>> 1) + (e >>> 3), sat(e - pv, 7) * 7});
      end
    end
  end
  task automatic send(int ch, int des, int act);
    in_vld = 1'b1;
    in_ch = 2'(ch);
    desired = 16'(des);
    actual = 16'(act);
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_rdy) break;
      if (t > 60) begin
        check("accept_timeout", int'(in_rdy), 1);
        break;
      end
    end
    @(posedge clk);
    #1 in_vld = 1'b0;
  endtask
  task automatic send_rnd();
    int d = int'($urandom_range(0, 65535));
    int a = $urandom_range(0, 1) ? int'($urandom_range(0, 65535)) : d + int'($urandom_range(0, 1200)) - 600;
    send(int'($urandom_range(0, 2)), d, a);
  endtask
  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    int hold_p, hold_d;
    bit done;
    rst = 1'b1; in_vld = 1'b0; in_ch = '0; desired = '0; actual = '0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_vld", int'(out_vld), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_pterm", int'(pterm), 0);
    check("rst_dterm", int'(dterm), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_rdy", int'(in_rdy), 1);
    @(posedge clk);
    #1;
    send(0, 'h23C4, 'h2307);
    drain();
    check("s1_pterm", last_p[0], -119);
    check("s1_dterm", last_d[0], -448);
    check("s1_ch", last_ch, 0);
    send(1, 0, 'h1000);
    drain();
    check("s2_pterm", last_p[1], 318);
    check("s2_dterm", last_d[1], 441);
    for (int i = 0; i < 13; i++) begin
      send(2, 0, i < 12 ? 'h1000 : 0);
      send(int'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    end
    drain();
    check("s3_441_count", ch2_441, 12);
    check("s3_last_dterm", last_d[2], -448);
    out_rdy = 1'b0;
    send(0, 100, 300);
    send(1, 500, -200);
    send(2, -30, 40);
    in_vld = 1'b1; in_ch = 2'd0; desired = 16'd7; actual = 16'd1000;
    @(negedge clk);
    hold_p = int'($signed(pterm));
    hold_d = int'($signed(dterm));
    repeat (5) begin
      @(negedge clk);
      check("stall_in_rdy", int'(in_rdy), 0);
      check("stall_out_vld", int'(out_vld), 1);
      check("stall_hold_p", int'($signed(pterm)), hold_p);
      check("stall_hold_d", int'($signed(dterm)), hold_d);
    end
    @(posedge clk);
    #1 out_rdy = 1'b1;
    send(0, 7, 1000);
    drain();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) send_rnd();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_rdy = $urandom_range(0, 3) != 0;
        end
      end
    join
    out_rdy = 1'b1;
    drain();
    send(1, 1000, -3000);
    send(2, -5000, 20);
    send(0, 12, 13);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_vld", int'(out_vld), 0);
    check("mid_rst_in_rdy", int'(in_rdy), 1);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_out", int'(out_vld), 0);
    end
    @(posedge clk);
    #1;
    last_p[0] = 0;
    last_d[0] = 0;
    send(0, 'h23C4, 'h2307);
    drain();
    check("s5_pterm", last_p[0], -119);
    check("s5_dterm", last_d[0], -448);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
